// File: rtl/intersection_controller.sv
// Four-way intersection phase sequencer with all-red clearance, directional
// emergency preemption and latched pedestrian walk requests.
module intersection_controller #(
    parameter int LEFT_CYC  = 5,
    parameter int GREEN_CYC = 10,
    parameter int YEL_CYC   = 3,
    parameter int CLR_CYC   = 1,
    parameter int CW        = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       emergency,
    input  logic       emg_dir,
    input  logic       ped_req_ns,
    input  logic       ped_req_ew,
    output logic [3:0] ns_out,
    output logic [3:0] ew_out,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic       preempt,
    output logic [3:0] phase
);

    typedef enum logic [3:0] {
        NS_L   = 4'd0,
        NS_G   = 4'd1,
        NS_Y   = 4'd2,
        CLR_NS = 4'd3,
        EW_L   = 4'd4,
        EW_G   = 4'd5,
        EW_Y   = 4'd6,
        CLR_EW = 4'd7,
        EMG    = 4'd8
    } state_t;

    localparam logic [3:0] LAMP_LEFT  = 4'b1001;
    localparam logic [3:0] LAMP_GREEN = 4'b0100;
    localparam logic [3:0] LAMP_YEL   = 4'b0010;
    localparam logic [3:0] LAMP_RED   = 4'b0001;

    localparam logic [CW-1:0] LEFT_LAST  = CW'(LEFT_CYC - 1);
    localparam logic [CW-1:0] GREEN_LAST = CW'(GREEN_CYC - 1);
    localparam logic [CW-1:0] YEL_LAST   = CW'(YEL_CYC - 1);
    localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYC - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          pend_dir_q, pend_dir_d;
    logic          latch_ns_q, latch_ns_d;
    logic          latch_ew_q, latch_ew_d;
    logic          walk_ns_q, walk_ns_d;
    logic          walk_ew_q, walk_ew_d;
    logic          preempt_q, preempt_d;
    logic [3:0]    ns_out_q, ns_out_d;
    logic [3:0]    ew_out_q, ew_out_d;

    logic          cnt_last;
    logic          lat_ns, lat_ew;

    function automatic logic [CW-1:0] phase_last(input state_t s);
        case (s)
            NS_L, EW_L:     phase_last = LEFT_LAST;
            NS_G, EW_G:     phase_last = GREEN_LAST;
            NS_Y, EW_Y:     phase_last = YEL_LAST;
            CLR_NS, CLR_EW: phase_last = CLR_LAST;
            default:        phase_last = '0;
        endcase
    endfunction

    function automatic state_t next_phase(input state_t s);
        case (s)
            NS_L:    next_phase = NS_G;
            NS_G:    next_phase = NS_Y;
            NS_Y:    next_phase = CLR_NS;
            CLR_NS:  next_phase = EW_L;
            EW_L:    next_phase = EW_G;
            EW_G:    next_phase = EW_Y;
            EW_Y:    next_phase = CLR_EW;
            default: next_phase = NS_L;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        pend_d     = pend_q;
        pend_dir_d = pend_dir_q;
        cnt_last   = (cnt_q == phase_last(state_q));

        if (state_q == EMG) begin
            cnt_d = '0;
            if (!emergency) begin
                state_d = pend_dir_q ? EW_Y : NS_Y;
                pend_d  = 1'b0;
            end
        end else begin
            // A trigger counts as pending on the very edge it is captured.
            if (emergency && !pend_q) begin
                pend_d     = 1'b1;
                pend_dir_d = emg_dir;
            end else if (!emergency) begin
                pend_d = 1'b0;
            end

            if (pend_d) begin
                case (state_q)
                    NS_L, NS_G: state_d = pend_dir_d ? NS_Y : EMG;
                    EW_L, EW_G: state_d = pend_dir_d ? EMG : EW_Y;
                    default: begin
                        if (cnt_last) begin
                            state_d = (state_q == CLR_NS || state_q == CLR_EW) ? EMG
                                                                              : next_phase(state_q);
                        end
                    end
                endcase
            end else if (cnt_last) begin
                state_d = next_phase(state_q);
            end
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        lat_ns     = latch_ns_q | ped_req_ns;
        lat_ew     = latch_ew_q | ped_req_ew;
        latch_ns_d = lat_ns;
        latch_ew_d = lat_ew;
        walk_ns_d  = 1'b0;
        walk_ew_d  = 1'b0;

        // Walk is granted only on entry to green; a request made during green waits.
        if (state_d == NS_G) begin
            if (state_q != NS_G) begin
                walk_ns_d  = lat_ns;
                latch_ns_d = 1'b0;
            end else begin
                walk_ns_d = walk_ns_q;
            end
        end
        if (state_d == EW_G) begin
            if (state_q != EW_G) begin
                walk_ew_d  = lat_ew;
                latch_ew_d = 1'b0;
            end else begin
                walk_ew_d = walk_ew_q;
            end
        end

        ns_out_d = LAMP_RED;
        ew_out_d = LAMP_RED;
        case (state_d)
            NS_L:    ns_out_d = LAMP_LEFT;
            NS_G:    ns_out_d = LAMP_GREEN;
            NS_Y:    ns_out_d = LAMP_YEL;
            EW_L:    ew_out_d = LAMP_LEFT;
            EW_G:    ew_out_d = LAMP_GREEN;
            EW_Y:    ew_out_d = LAMP_YEL;
            EMG: begin
                if (pend_dir_d) ew_out_d = LAMP_GREEN;
                else            ns_out_d = LAMP_GREEN;
            end
            default: ;
        endcase

        preempt_d = pend_d | (state_d == EMG);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= NS_L;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_dir_q <= 1'b0;
            latch_ns_q <= 1'b0;
            latch_ew_q <= 1'b0;
            walk_ns_q  <= 1'b0;
            walk_ew_q  <= 1'b0;
            preempt_q  <= 1'b0;
            ns_out_q   <= LAMP_LEFT;
            ew_out_q   <= LAMP_RED;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_dir_q <= pend_dir_d;
            latch_ns_q <= latch_ns_d;
            latch_ew_q <= latch_ew_d;
            walk_ns_q  <= walk_ns_d;
            walk_ew_q  <= walk_ew_d;
            preempt_q  <= preempt_d;
            ns_out_q   <= ns_out_d;
            ew_out_q   <= ew_out_d;
        end
    end

    assign ns_out  = ns_out_q;
    assign ew_out  = ew_out_q;
    assign walk_ns = walk_ns_q;
    assign walk_ew = walk_ew_q;
    assign preempt = preempt_q;
    assign phase   = state_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed plus randomized bench for intersection_controller, checked against a
// phase/remaining-time reference model of the signal plan.
module tb_intersection_controller;

    localparam int LEFT_CYC  = 5;
    localparam int GREEN_CYC = 10;
    localparam int YEL_CYC   = 3;
    localparam int CLR_CYC   = 1;

    logic       clk;
    logic       rst;
    logic       emergency;
    logic       emg_dir;
    logic       ped_req_ns;
    logic       ped_req_ew;
    logic [3:0] ns_out;
    logic [3:0] ew_out;
    logic       walk_ns;
    logic       walk_ew;
    logic       preempt;
    logic [3:0] phase;

    int assertions_made = 0;
    int failures        = 0;

    // Model: position 0..7 in the plan (dir*4 + kind), 8 = emergency hold.
    int m_ph;
    int m_rem;
    int m_pend;
    int m_pdir;
    int m_latch[2];
    int m_walk[2];
    int dur[4];
    logic [3:0] lamp[4];

    intersection_controller #(
        .LEFT_CYC (LEFT_CYC),
        .GREEN_CYC(GREEN_CYC),
        .YEL_CYC  (YEL_CYC),
        .CLR_CYC  (CLR_CYC),
        .CW       (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .emergency (emergency),
        .emg_dir   (emg_dir),
        .ped_req_ns(ped_req_ns),
        .ped_req_ew(ped_req_ew),
        .ns_out    (ns_out),
        .ew_out    (ew_out),
        .walk_ns   (walk_ns),
        .walk_ew   (walk_ew),
        .preempt   (preempt),
        .phase     (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_ph     = 0;
        m_rem    = LEFT_CYC;
        m_pend   = 0;
        m_pdir   = 0;
        m_latch[0] = 0; m_latch[1] = 0;
        m_walk[0]  = 0; m_walk[1]  = 0;
    endtask

    task automatic model_step(input int e, input int d, input int pn, input int pe);
        int old_ph, dir, kind, req, le, g;
        old_ph = m_ph;
        if (m_ph == 8) begin
            if (e == 0) begin
                m_ph   = m_pdir * 4 + 2;
                m_rem  = dur[2];
                m_pend = 0;
            end
        end else begin
            if (e != 0 && m_pend == 0) m_pdir = d;
            m_pend = e;
            dir  = m_ph / 4;
            kind = m_ph % 4;
            if (m_pend != 0 && kind < 2) begin
                if (dir == m_pdir) m_ph = 8;
                else begin
                    m_ph  = dir * 4 + 2;
                    m_rem = dur[2];
                end
            end else if (m_rem == 1) begin
                if (m_pend != 0 && kind == 3) m_ph = 8;
                else begin
                    m_ph  = (m_ph + 1) % 8;
                    m_rem = dur[m_ph % 4];
                end
            end else begin
                m_rem = m_rem - 1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            req = (i == 0) ? pn : pe;
            le  = (m_latch[i] != 0 || req != 0) ? 1 : 0;
            g   = i * 4 + 1;
            if (m_ph == g && old_ph != g) begin
                m_walk[i]  = le;
                m_latch[i] = 0;
            end else if (m_ph == g) begin
                m_latch[i] = le;
            end else begin
                m_walk[i]  = 0;
                m_latch[i] = le;
            end
        end
    endtask

    function automatic logic [3:0] exp_lamp(input int dir);
        if (m_ph == 8) return (m_pdir == dir) ? 4'b0100 : 4'b0001;
        if (m_ph / 4 == dir) return lamp[m_ph % 4];
        return 4'b0001;
    endfunction

    task automatic checkValue(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        assertions_made++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".ns_out"}, ns_out, exp_lamp(0));
        checkValue({tag, ".ew_out"}, ew_out, exp_lamp(1));
        checkValue({tag, ".walk_ns"}, {3'b0, walk_ns}, 4'(m_walk[0]));
        checkValue({tag, ".walk_ew"}, {3'b0, walk_ew}, 4'(m_walk[1]));
        checkValue({tag, ".preempt"}, {3'b0, preempt}, 4'((m_pend != 0 || m_ph == 8) ? 1 : 0));
        checkValue({tag, ".phase"}, phase, 4'(m_ph));
        checkValue({tag, ".one_red"}, {3'b0, (ns_out == 4'b0001 || ew_out == 4'b0001)}, 4'd1);
    endtask

    task automatic applyStimulus(input string tag, input int e, input int d, input int pn, input int pe);
        emergency  = 1'(e);
        emg_dir    = 1'(d);
        ped_req_ns = 1'(pn);
        ped_req_ew = 1'(pe);
        @(posedge clk);
        model_step(e, d, pn, pe);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        int walk_ew_cnt, walk_ns_cnt, e_rand, d_rand;
        dur[0] = LEFT_CYC; dur[1] = GREEN_CYC; dur[2] = YEL_CYC; dur[3] = CLR_CYC;
        lamp[0] = 4'b1001; lamp[1] = 4'b0100; lamp[2] = 4'b0010; lamp[3] = 4'b0001;

        rst = 1'b1; emergency = 1'b0; emg_dir = 1'b0; ped_req_ns = 1'b0; ped_req_ew = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        checkValue("reset.ns_const", ns_out, 4'b1001);
        rst = 1'b0;

        $display("[TB] idle full cycle");
        for (int i = 1; i <= 38; i++) begin
            applyStimulus("idle", 0, 0, 0, 0);
            if (i == 5)  checkValue("idle.ns_green", ns_out, 4'b0100);
            if (i == 15) checkValue("idle.ns_yellow", ns_out, 4'b0010);
            if (i == 18) checkValue("idle.all_red", {ns_out[0], ew_out[0], ns_out[3:2]}, 4'b1100);
            if (i == 19) checkValue("idle.ew_left", ew_out, 4'b1001);
        end
        checkValue("idle.wrap_ns_left", ns_out, 4'b1001);

        $display("[TB] pedestrian EW request");
        walk_ew_cnt = 0; walk_ns_cnt = 0;
        for (int i = 0; i < 38; i++) begin
            applyStimulus("ped", 0, 0, 0, (i == 1) ? 1 : 0);
            walk_ew_cnt += int'(walk_ew);
            walk_ns_cnt += int'(walk_ns);
        end
        checkValue("ped.walk_ew_cycles", 4'(walk_ew_cnt), 4'd10);
        checkValue("ped.walk_ns_cycles", 4'(walk_ns_cnt), 4'd0);

        $display("[TB] emergency NS during NS green");
        for (int i = 0; i < 8; i++) applyStimulus("emg_ns", 0, 0, 0, 0);
        applyStimulus("emg_ns.trig", 1, 0, 0, 0);
        checkValue("emg_ns.green", ns_out, 4'b0100);
        checkValue("emg_ns.phase", phase, 4'd8);
        for (int i = 0; i < 3; i++) applyStimulus("emg_ns.hold", 1, 1, 0, 0);
        applyStimulus("emg_ns.drop", 0, 0, 0, 0);
        checkValue("emg_ns.yellow", ns_out, 4'b0010);
        for (int i = 0; i < 4; i++) applyStimulus("emg_ns.after", 0, 0, 0, 0);
        checkValue("emg_ns.ew_left", ew_out, 4'b1001);

        $display("[TB] emergency NS during EW green");
        for (int i = 0; i < 7; i++) applyStimulus("emg_ew", 0, 0, 0, 0);
        applyStimulus("emg_ew.trig", 1, 0, 0, 0);
        checkValue("emg_ew.ew_yellow", ew_out, 4'b0010);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("emg_ew.run", 1, 1, 0, 0);
            checkValue("emg_ew.preempt", {3'b0, preempt}, 4'd1);
        end
        checkValue("emg_ew.ns_green", ns_out, 4'b0100);
        applyStimulus("emg_ew.drop", 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus("emg_ew.after", 0, 0, 0, 0);

        $display("[TB] one-cycle emergency pulse");
        applyStimulus("pulse.trig", 1, 0, 0, 0);
        checkValue("pulse.ew_yellow", ew_out, 4'b0010);
        applyStimulus("pulse.drop", 0, 0, 0, 0);
        checkValue("pulse.preempt_low", {3'b0, preempt}, 4'd0);
        for (int i = 0; i < 3; i++) applyStimulus("pulse.after", 0, 0, 0, 0);
        checkValue("pulse.ns_left", ns_out, 4'b1001);

        $display("[TB] async reset during EMG");
        applyStimulus("areset.trig", 1, 0, 0, 0);
        checkValue("areset.in_emg", phase, 4'd8);
        #2 rst = 1'b1;
        #1;
        model_reset();
        checkOutput("areset.async");
        @(posedge clk);
        #1;
        rst = 1'b0; emergency = 1'b0;
        checkOutput("areset.held");

        $display("[TB] randomized traffic");
        e_rand = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) e_rand = 1 - e_rand;
            d_rand = int'($urandom_range(0, 1));
            applyStimulus("rand", e_rand, d_rand,
                          ($urandom_range(0, 19) == 0) ? 1 : 0,
                          ($urandom_range(0, 19) == 0) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions_made, failures);
        $finish;
    end

endmodule
